// File: rtl/fir_ram_delay_line_pkg.sv
// Shared types for the FIR sample history store.
// FSM states, sticky error bit codes and the lane address type.
package fir_ram_pkg;

  typedef enum logic [1:0] {
    CLEAR_S,
    IDLE_S,
    START_S,
    READ_S
  } state_t;

  localparam logic [1:0] ERR_OVERRUN    = 2'h1;
  localparam logic [1:0] ERR_RD_ILLEGAL = 2'h2;

  // Wide enough for any practical tap count; banks slice to AWIDTH.
  localparam int LANE_AW_MAX = 16;

  typedef logic [LANE_AW_MAX-1:0] lane_addr_t;

endpackage

// File: rtl/fir_ram_delay_line_if.sv
// Sample stream in, compute-core start/read bus out.
// master drives samples and strobes; slave is the history store.
interface fir_ram_delay_line_if #(
  parameter int DATA_WIDTH = 16,
  parameter int PARALLEL   = 4
);

  logic signed [DATA_WIDTH-1:0]     data_i;
  logic                             data_val_i;
  logic                             ready_o;
  logic                             fir_start_o;
  logic                             ram_rd_i;
  logic [DATA_WIDTH*PARALLEL-1:0]   ram_data_o;

  modport master (
    output data_i,
    output data_val_i,
    output ram_rd_i,
    input  ready_o,
    input  fir_start_o,
    input  ram_data_o
  );

  modport slave (
    input  data_i,
    input  data_val_i,
    input  ram_rd_i,
    output ready_o,
    output fir_start_o,
    output ram_data_o
  );

endinterface

// File: rtl/fir_ram_delay_line_bank.sv
// One history RAM copy serving a single multiplier lane.
// Two-cycle read: registered address, then registered data.
module fir_ram_bank
  import fir_ram_pkg::*;
#(
  parameter int         DATA_WIDTH = 16,
  parameter int         AWIDTH     = 8,
  parameter lane_addr_t LANE_OFF   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [AWIDTH-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  rd_i,
  input  logic [AWIDTH-1:0]     base_i,
  input  logic [AWIDTH-1:0]     k_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH-1:0] OFF =
    LANE_OFF[AWIDTH-1:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0]     raddr_q;
  logic                  rd_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Address wraps mod DEPTH, giving x[n - OFF - k].
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      raddr_q <= '0;
      rd_q    <= 1'b0;
      rdata_o <= '0;
    end else begin
      rd_q <= rd_i;
      if (rd_i) begin
        raddr_q <= base_i - OFF - k_i;
      end
      if (rd_q) begin
        rdata_o <= mem[raddr_q];
      end
    end
  end

endmodule

// File: rtl/fir_ram_delay_line.sv
// Circular sample history feeding a RAM-based FIR core.
// Zeroes history, pulses start per sample, serves lane reads.
module fir_ram_delay_line
  import fir_ram_pkg::*;
#(
  parameter int FILTER_ORDER = 256,
  parameter int DATA_WIDTH   = 16,
  parameter int PARALLEL     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  fir_ram_delay_line_if.slave  bus,
  output logic [1:0]           err_flg_o
);

  localparam int ITERATION = FILTER_ORDER / PARALLEL;
  localparam int AWIDTH    = $clog2(FILTER_ORDER);

  localparam logic [AWIDTH-1:0] A_ONE =
    AWIDTH'(1);
  localparam logic [AWIDTH-1:0] CLR_LAST =
    AWIDTH'(FILTER_ORDER - 1);
  localparam logic [AWIDTH-1:0] K_LAST =
    AWIDTH'(ITERATION - 1);

  if ((FILTER_ORDER & (FILTER_ORDER - 1)) != 0 ||
      (FILTER_ORDER % PARALLEL) != 0 ||
      AWIDTH > LANE_AW_MAX) begin : g_bad_cfg
    $error("fir_ram_delay_line: bad FILTER_ORDER/PARALLEL");
  end

  state_t                  state_q;
  state_t                  state_d;
  logic [AWIDTH-1:0]       clr_q;
  logic [AWIDTH-1:0]       wr_ptr_q;
  logic [AWIDTH-1:0]       base_q;
  logic [AWIDTH-1:0]       k_q;
  logic                    pend_vld_q;
  logic [DATA_WIDTH-1:0]   pend_q;
  logic [1:0]              err_q;

  logic                    in_clr;
  logic                    in_idle;
  logic                    in_start;
  logic                    in_read;
  logic                    take;
  logic                    rd_ok;
  logic                    ovr;
  logic                    rd_ill;
  logic                    we;
  logic [AWIDTH-1:0]       waddr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [1:0]              err_set;
  logic [DATA_WIDTH*PARALLEL-1:0] lanes;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= CLEAR_S;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = CLEAR_S;
    end else begin
      unique case (state_q)
        CLEAR_S: if (clr_q == CLR_LAST) state_d = IDLE_S;
        IDLE_S:  if (take) state_d = START_S;
        START_S: state_d = READ_S;
        READ_S:  if (rd_ok && k_q == K_LAST) state_d = IDLE_S;
        default: state_d = CLEAR_S;
      endcase
    end
  end

  always_comb begin
    in_clr   = (state_q == CLEAR_S);
    in_idle  = (state_q == IDLE_S);
    in_start = (state_q == START_S);
    in_read  = (state_q == READ_S);
    take     = in_idle && !flush_i &&
               (bus.data_val_i || pend_vld_q);
    rd_ok    = in_read && !flush_i && bus.ram_rd_i;
    // Pending slot counts as full until IDLE drains it.
    ovr      = bus.data_val_i && !flush_i &&
               (in_clr || ((in_start || in_read) && pend_vld_q));
    rd_ill   = bus.ram_rd_i && !in_read;
    we       = in_clr || take;
    waddr    = in_clr ? clr_q : wr_ptr_q + A_ONE;
    wdata    = '0;
    if (!in_clr) begin
      wdata = pend_vld_q ? pend_q : bus.data_i;
    end
    err_set  = (ovr ? ERR_OVERRUN : 2'b00) |
               (rd_ill ? ERR_RD_ILLEGAL : 2'b00);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clr_q      <= '0;
      wr_ptr_q   <= '0;
      base_q     <= '0;
      k_q        <= '0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      err_q      <= '0;
    end else begin
      err_q <= err_q | err_set;
      if (flush_i) begin
        clr_q      <= '0;
        wr_ptr_q   <= '0;
        k_q        <= '0;
        pend_vld_q <= 1'b0;
      end else begin
        if (in_clr) begin
          clr_q    <= clr_q + A_ONE;
          wr_ptr_q <= '0;
        end
        if (take) begin
          wr_ptr_q <= waddr;
          if (pend_vld_q) pend_vld_q <= 1'b0;
        end
        if (in_start) begin
          base_q <= wr_ptr_q;
          k_q    <= '0;
        end
        if (rd_ok) begin
          k_q <= k_q + A_ONE;
        end
        if (bus.data_val_i && !in_clr && !ovr) begin
          // Direct IDLE writes bypass the slot unless it is draining.
          if (!in_idle || pend_vld_q) begin
            pend_q     <= bus.data_i;
            pend_vld_q <= 1'b1;
          end
        end
      end
    end
  end

  for (genvar i = 0; i < PARALLEL; i++) begin : g_bank
    fir_ram_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .AWIDTH     (AWIDTH),
      .LANE_OFF   (lane_addr_t'(i * ITERATION))
    ) u_bank (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .rd_i    (rd_ok),
      .base_i  (base_q),
      .k_i     (k_q),
      .rdata_o (lanes[DATA_WIDTH*i +: DATA_WIDTH])
    );
  end

  assign bus.ram_data_o  = lanes;
  assign bus.fir_start_o = in_start;
  assign bus.ready_o     = in_idle && !pend_vld_q;
  assign err_flg_o       = err_q;

endmodule

// File: tb/tb_fir_ram_delay_line.sv
// Directed bench for fir_ram_delay_line, 16 taps x 4 lanes.
// Expected lane vectors are hand-derived sample indices.
module tb_fir_ram_delay_line;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [1:0] err;

  int checks = 0;
  int errors = 0;
  int starts = 0;

  logic [63:0] vec [4];
  logic start_r4;

  fir_ram_delay_line_if #(
    .DATA_WIDTH (16),
    .PARALLEL   (4)
  ) bus ();

  fir_ram_delay_line #(
    .FILTER_ORDER (16),
    .DATA_WIDTH   (16),
    .PARALLEL     (4)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .flush_i   (flush),
    .bus       (bus),
    .err_flg_o (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.fir_start_o === 1'b1) starts++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] lv(
    input int l0, input int l1, input int l2, input int l3);
    return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
  endfunction

  // Four back-to-back strobes from the current READ cycle r.
  task automatic burst(input bit inj);
    bus.ram_rd_i = 1'b1;
    if (inj) begin
      bus.data_val_i = 1'b1;
      bus.data_i = 16'd99;
    end
    tick();
    if (inj) bus.data_i = 16'd100;
    tick();
    bus.data_val_i = 1'b0;
    vec[0] = bus.ram_data_o;
    tick();
    vec[1] = bus.ram_data_o;
    tick();
    bus.ram_rd_i = 1'b0;
    vec[2] = bus.ram_data_o;
    start_r4 = bus.fir_start_o;
    tick();
    vec[3] = bus.ram_data_o;
  endtask

  task automatic push(input int d);
    bus.data_i = 16'(d);
    bus.data_val_i = 1'b1;
    tick();
    bus.data_val_i = 1'b0;
    tick();
  endtask

  task automatic sample(input int d);
    chk($sformatf("ready_before_%0d", d), 64'(bus.ready_o), 64'd1);
    push(d);
    burst(1'b0);
  endtask

  task automatic clear_len(input string tag);
    int n = 0;
    while (bus.ready_o !== 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk(tag, 64'(n), 64'd16);
  endtask

  initial begin
    int s0;
    bus.data_i = '0;
    bus.data_val_i = 1'b0;
    bus.ram_rd_i = 1'b0;
    tick();
    tick();
    chk("rst_start", 64'(bus.fir_start_o), 64'd0);
    chk("rst_data", bus.ram_data_o, 64'd0);
    chk("rst_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_err", 64'(err), 64'd0);

    rst = 1'b0;
    clear_len("reset_clear_len");

    // Single sample into zeroed history.
    sample(7);
    chk("t1_k0", vec[0], lv(7, 0, 0, 0));
    chk("t1_k1", vec[1], lv(0, 0, 0, 0));
    chk("t1_k2", vec[2], lv(0, 0, 0, 0));
    chk("t1_k3", vec[3], lv(0, 0, 0, 0));

    s0 = starts;
    for (int d = 1; d <= 16; d++) sample(d);
    chk("t2_starts", 64'(starts - s0), 64'd16);
    chk("t2_k0", vec[0], lv(16, 12, 8, 4));
    chk("t2_k1", vec[1], lv(15, 11, 7, 3));
    chk("t2_k3", vec[3], lv(13, 9, 5, 1));

    for (int d = 17; d <= 20; d++) sample(d);
    chk("t3_k0", vec[0], lv(20, 16, 12, 8));
    chk("t3_k3", vec[3], lv(17, 13, 9, 5));
    chk("t3_err", 64'(err), 64'd0);

    // 99 held in pending, 100 dropped as overrun.
    chk("t4_ready", 64'(bus.ready_o), 64'd1);
    push(21);
    burst(1'b1);
    chk("t4_own_k0", vec[0], lv(21, 17, 13, 9));
    chk("t4_start_r4", 64'(start_r4), 64'd0);
    chk("t4_start_r5", 64'(bus.fir_start_o), 64'd1);
    chk("t4_err", 64'(err), 64'd1);
    tick();
    burst(1'b0);
    chk("t4_pend_k0", vec[0], lv(99, 18, 14, 10));

    // Stray strobe while idle.
    bus.ram_rd_i = 1'b1;
    tick();
    bus.ram_rd_i = 1'b0;
    chk("t5_err", 64'(err), 64'd3);
    sample(22);
    chk("t5_k0", vec[0], lv(22, 19, 15, 11));
    chk("t5_k3", vec[3], lv(20, 16, 12, 8));

    // Flush after two strobes of a read sequence.
    chk("t6_ready", 64'(bus.ready_o), 64'd1);
    push(23);
    bus.ram_rd_i = 1'b1;
    tick();
    tick();
    bus.ram_rd_i = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t6_start", 64'(bus.fir_start_o), 64'd0);
    clear_len("flush_clear_len");
    sample(5);
    chk("t6_k0", vec[0], lv(5, 0, 0, 0));
    chk("t6_k1", vec[1], lv(0, 0, 0, 0));
    chk("t6_k3", vec[3], lv(0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
